uart_tx: RTL
============

Name: uart_tx

Overview:
- 8N1 UART transmitter.
- Companion to the UART receiver on the same serial link.
- Accepts bytes from the core through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte onto io_tx: LSB first, one start bit, one stop bit, idle-high line.

Parameters:
- BAUD, 4800, line bit rate in bits/s.
- FREQUENCY_IN_HZ, 80_000_000, clk frequency.
- FIFO_DEPTH, 4, byte buffer entries; power of two, >= 2.
- Derived constant CLKS_PER_BIT = FREQUENCY_IN_HZ / BAUD (integer division; 16666 at defaults).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- io_data_valid  input  1  byte on io_data_packet is offered this cycle
- io_data_packet  input  8  byte to transmit
- io_ready  output  1  FIFO can accept a byte (not full)
- io_tx  output  1  serial line, registered output
- io_busy  output  1  FIFO non-empty or a frame in progress

Behaviour:
- Clock/reset: clk and rst as above; rst is synchronous, active-high. All state updates on the rising edge of clk.
- Reset values: io_tx=1, io_ready=1, io_busy=0; FIFO empty (rd_ptr=wr_ptr=count=0); state=idle; baud counter=0; bit index=0; shift register=0.
- Handshake: a byte is accepted at the edge where io_data_valid && io_ready.
  - io_ready = (count != FIFO_DEPTH), combinational from the registered count.
  - Offers while full are ignored; the byte is dropped, and it is the producer's job to hold valid.
  - io_data_packet is sampled only at the accepting edge.
- FIFO: circular buffer with wrap-around pointers of width log2(FIFO_DEPTH).
  - Push and pop in the same cycle leave count unchanged; both pointers advance.
  - Pop when full with simultaneous valid: io_ready was already 0 that cycle, so no push.
- FSM states: idle, start_bit, data_bit, stop_bit.
  - idle: io_tx=1. If count>0: pop head into shift register, counter=0, io_tx<=0, go to start_bit.
  - start_bit: counter increments each cycle. When counter==CLKS_PER_BIT-1: counter=0, bit index=0, io_tx<=shift[0], go to data_bit.
  - data_bit: counter increments. When counter==CLKS_PER_BIT-1: counter=0.
    - If bit index==7: io_tx<=1, go to stop_bit.
    - Else: shift right by 1, bit index+1, io_tx<=next LSB.
  - stop_bit: counter increments. When counter==CLKS_PER_BIT-1: counter=0.
    - If count>0: pop, io_tx<=0, go directly to start_bit (back-to-back frames, no idle gap).
    - Else: go to idle.
- Timing:
  - Every bit, including start and stop, is held exactly CLKS_PER_BIT cycles.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - Latency: byte accepted at edge N into an empty, idle block -> io_tx falls at edge N+1.
- io_busy = (count != 0) || (state != idle), registered-derived; deasserts in the cycle the FSM returns to idle with the FIFO empty.
- A push during a frame never disturbs the current frame.
- Reset mid-frame: at the reset edge, io_tx returns to 1, the frame is aborted, and the FIFO contents are discarded.
- io_tx has no glitches: it only changes at bit boundaries.

Test Plan:
- Reset: hold rst 3 cycles while io_data_valid=1 -> io_tx=1, io_ready=1, io_busy=0, nothing accepted.
- Single byte, FREQUENCY_IN_HZ=80_000_000, BAUD=10_000_000 (CLKS_PER_BIT=8): send 0xA5 -> io_tx falls 1 cycle after acceptance, then 8 cycles each of 0,1,0,1,0,0,1,0,1,1; io_busy low after 80 cycles.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous 80-cycle frames, no idle gap; sampling a receiver at bit centres recovers 0x00, 0xFF, 0x55.
- Full FIFO: push 6 bytes 0x01..0x06 with valid held high (FIFO_DEPTH=4) -> io_ready drops after 0x05 (first byte popped into the shifter); 0x06 is accepted when a slot frees; all six bytes are transmitted in order.
- Wrap-around: stream 10 bytes 0x10..0x19 with a random valid pattern -> transmitted order is identical, no loss or duplication.
- Reset mid-frame: assert rst during data bit 3 of 0x3C with 2 bytes queued -> io_tx=1 the next cycle, no further frames, io_busy=0.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes enter through a valid/ready handshake into a small
// circular FIFO and are shifted out LSB first with one start and one stop bit.
module uart_tx #(
  parameter int BAUD            = 4800,
  parameter int FREQUENCY_IN_HZ = 80_000_000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_data_valid,
  input  logic [7:0] io_data_packet,
  output logic       io_ready,
  output logic       io_tx,
  output logic       io_busy
);

  localparam int CLKS_PER_BIT = FREQUENCY_IN_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W       = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [CNT_W-1:0]  w_baud_cnt_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_next;
  logic              r_tx;
  logic              w_tx_next;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [FCNT_W-1:0] r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_fifo_nonempty;
  logic [7:0]        w_head;

  assign w_bit_end       = (r_baud_cnt == LAST_CNT);
  assign w_fifo_nonempty = (r_count != '0);
  // Head is read asynchronously so a pop can load the shifter on the same edge.
  assign w_head          = r_mem[r_rd_ptr];
  assign io_tx           = r_tx;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= io_data_packet;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_tx_next       = r_tx;

    case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        if (w_pop) begin
          w_shift_next    = w_head;
          w_baud_cnt_next = '0;
          w_tx_next       = 1'b0;
          w_state_next    = ST_START;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          w_bit_idx_next  = '0;
          w_tx_next       = r_shift[0];
          w_state_next    = ST_DATA;
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = ST_STOP;
          end else begin
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[1];
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          // A queued byte starts its frame immediately, with no idle gap.
          if (w_pop) begin
            w_shift_next = w_head;
            w_tx_next    = 1'b0;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next    = ST_IDLE;
        w_baud_cnt_next = '0;
        w_tx_next       = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    io_ready = (r_count != FULL_CNT);
    io_busy  = w_fifo_nonempty || (r_state != ST_IDLE);
    w_push   = io_data_valid && (r_count != FULL_CNT);
    w_pop    = 1'b0;
    if (r_state == ST_IDLE) begin
      w_pop = w_fifo_nonempty;
    end else if (r_state == ST_STOP) begin
      w_pop = w_fifo_nonempty && w_bit_end;
    end
  end

endmodule
